// File: rtl/knight_rider_pkg.sv
// Shared constants for the knight-rider scanner and its LED fader stage.
package knight_rider_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned LED_COUNT    = 10;
  localparam int unsigned POS_W        = 4;

  localparam logic [PWM_BITS_DEF-1:0] FULL_BRIGHTNESS = {PWM_BITS_DEF{1'b1}};

endpackage

// File: rtl/fader_channel.sv
// One LED channel: a brightness register that decays on each step and a registered
// PWM compare against the shared free-running counter.
module fader_channel
  import knight_rider_pkg::*;
#(
  parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
  parameter int unsigned DECAY_SHIFT = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                step_tick,
  input  logic                is_current,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] Full = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] brightness_d, brightness_q;
  logic                led_d, led_q;

  // Next brightness: current LED jumps to full, everything else decays; hold between steps.
  always_comb begin
    brightness_d = brightness_q;
    if (step_tick) begin
      brightness_d = is_current ? Full : (brightness_q >> DECAY_SHIFT);
    end
  end

  // PWM compare; full brightness forced on so it never shows a one-cycle gap at wrap.
  always_comb begin
    led_d = (brightness_q == Full) | (pwm_cnt < brightness_q);
  end

  // Brightness and LED drive registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      brightness_q <= '0;
      led_q        <= 1'b0;
    end else begin
      brightness_q <= brightness_d;
      led_q        <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/knight_rider_fader.sv
// Comet-tail PWM display stage: decodes the scanner position into per-channel
// "is current" strobes, runs the shared PWM counter and flags out-of-range positions.
module knight_rider_fader
  import knight_rider_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = LED_COUNT,
  parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
  parameter int unsigned DECAY_SHIFT = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                step_tick,
  input  logic [POS_W-1:0]    pos,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                pos_err
);

  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
  logic                pos_err_d, pos_err_q;
  logic                pos_valid;

  // Zero-extended compare so any NUM_LEDS works regardless of POS_W.
  assign pos_valid = (32'(pos) < NUM_LEDS);

  // Free-running PWM counter and sticky out-of-range flag.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
    pos_err_d = pos_err_q | (step_tick & ~pos_valid);
  end

  // Counter and error flag registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      pos_err_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pos_err_q <= pos_err_d;
    end
  end

  assign pos_err = pos_err_q;

  // An out-of-range pos matches no channel index, so every channel just decays.
  for (genvar g_ch = 0; g_ch < NUM_LEDS; g_ch++) begin : g_channel
    fader_channel #(
      .PWM_BITS    (PWM_BITS),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_channel (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .step_tick  (step_tick),
      .is_current (32'(pos) == g_ch),
      .pwm_cnt    (pwm_cnt_q),
      .led        (LEDR[g_ch])
    );
  end

endmodule

// File: tb/tb_knight_rider_fader.sv
// Scoreboard bench: the driver pushes the expected LEDR/pos_err for each upcoming edge,
// a monitor pops and compares shortly after every rising edge.
module tb_knight_rider_fader;

  localparam int N    = 10;
  localparam int FULL = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_tick = 1'b0;
  logic [3:0] pos = 4'd0;
  logic [N-1:0] LEDR;
  logic       pos_err;

  knight_rider_fader dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .step_tick (step_tick),
    .pos       (pos),
    .LEDR      (LEDR),
    .pos_err   (pos_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] led;
    logic         err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   m_b[N];
  int   m_pwm;
  bit   m_err;
  bit   mon_en = 1'b0;
  int   hi3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present inputs for the coming edge and queue what the outputs must be after it.
  task automatic drive(input bit st, input int p);
    exp_t e;
    step_tick = st;
    pos = p[3:0];
    for (int i = 0; i < N; i++) e.led[i] = (m_b[i] == FULL) || (m_pwm < m_b[i]);
    e.err = m_err || (st && p >= N);
    q.push_back(e);
    if (st) begin
      for (int i = 0; i < N; i++) m_b[i] = (i == p) ? FULL : m_b[i] / 2;
    end
    m_err = e.err;
    m_pwm = (m_pwm + 1) % 256;
  endtask

  task automatic cycle(input bit st, input int p);
    @(negedge clk);
    if (LEDR[3] === 1'b1) hi3++;
    drive(st, p);
  endtask

  // Assert reset right now, hold it, check cleared outputs, release at a falling edge.
  task automatic apply_reset();
    reset = 1'b1;
    step_tick = 1'b0;
    mon_en = 1'b0;
    q.delete();
    #1;
    check("async_reset_ledr", 32'(LEDR), 32'd0);
    check("async_reset_err", 32'(pos_err), 32'd0);
    repeat (3) @(negedge clk);
    check("held_reset_ledr", 32'(LEDR), 32'd0);
    reset = 1'b0;
    foreach (m_b[i]) m_b[i] = 0;
    m_pwm = 0;
    m_err = 1'b0;
    mon_en = 1'b1;
    drive(1'b0, 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got empty queue want entry at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        check("ledr", 32'(LEDR), 32'(mon_e.led));
        check("pos_err", 32'(pos_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    int p;
    apply_reset();

    // Idle: all dark, counter wraps several times.
    repeat (1000) cycle(1'b0, 0);

    // Single step on LED 3, then observe.
    cycle(1'b1, 3);
    repeat (5) cycle(1'b0, 0);

    // Move to 4: LED 3 at 127, measure its duty over one full PWM period.
    cycle(1'b1, 4);
    repeat (4) cycle(1'b0, 0);
    hi3 = 0;
    repeat (256) cycle(1'b0, 0);
    check("duty_led3_127", 32'(hi3), 32'd127);

    // Continue the sweep into out-of-range positions.
    for (int k = 5; k <= 11; k++) begin
      cycle(1'b1, k);
      repeat (3) cycle(1'b0, 0);
    end

    // Clean slate, then held step: LED1 full, three held steps on 0.
    @(posedge clk);
    #3;
    apply_reset();
    cycle(1'b1, 1);
    cycle(1'b0, 0);
    repeat (3) cycle(1'b1, 0);
    repeat (300) cycle(1'b0, 0);

    // Out-of-range step with LED 5 lit, then valid steps keep pos_err set.
    cycle(1'b1, 5);
    cycle(1'b1, 12);
    repeat (3) cycle(1'b0, 0);
    cycle(1'b1, 2);
    cycle(1'b1, 7);
    repeat (20) cycle(1'b0, 0);

    // Build intermediate brightness, then reset mid-period.
    cycle(1'b1, 6);
    cycle(1'b1, 7);
    cycle(1'b1, 8);
    repeat (37) cycle(1'b0, 0);
    @(posedge clk);
    #3;
    apply_reset();
    cycle(1'b1, 9);
    repeat (10) cycle(1'b0, 0);

    // Randomized steps and positions.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 19) == 0) p = 10 + int'($urandom_range(0, 5));
      else p = int'($urandom_range(0, 9));
      cycle($urandom_range(0, 3) == 0, p);
      if (k == 1000) begin
        @(posedge clk);
        #3;
        apply_reset();
      end
    end

    @(posedge clk);
    #3;
    mon_en = 1'b0;
    check("sb_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knight_rider_fader.md
Name: knight_rider_fader

Overview:
- Downstream display stage for the knight-rider scanner.
- Consumes the scanner's LED position (0..9) and a one-cycle step pulse in the CLOCK_50 domain.
- Drives LEDR with a PWM "comet tail": the current LED is at full brightness, and previously lit LEDs decay geometrically on each step.
- Replaces the direct one-hot assign; the scanner only supplies the position.

Parameters:
- NUM_LEDS, 10: number of LED channels driven.
- PWM_BITS, 8: width of brightness registers and the PWM counter.
- DECAY_SHIFT, 1: right-shift applied to every non-current brightness on each step (1 halves it).

Ports:
- CLOCK_50 input 1: system clock, 50 MHz; all state on its rising edge.
- reset input 1: asynchronous, active-high; clears all state.
- step_tick input 1: one-cycle pulse, synchronous to CLOCK_50; the scanner advanced.
- pos input 4: current scanner position; valid range 0..NUM_LEDS-1; sampled only when step_tick=1.
- LEDR output NUM_LEDS: registered PWM LED drive, bit i = LED i.
- pos_err output 1: sticky flag; set when step_tick samples pos >= NUM_LEDS.

Behaviour:
- Reset (async, any time, including mid-PWM-period): all brightness[i]=0, pwm_cnt=0, LEDR=0, pos_err=0. The first step after release starts from all-dark.
- pwm_cnt: free-running PWM_BITS counter, +1 every cycle, wraps 255->0 (period 256 cycles = 5.12 us).
- Brightness update, only in the cycle step_tick=1:
  - i == pos: brightness[i] <= FULL (all ones, 255).
  - i != pos: brightness[i] <= brightness[i] >> DECAY_SHIFT (logical shift, saturates at 0, no underflow).
- step_tick=0: brightness holds.
- step_tick held high for N cycles counts as N steps: pos LED stays FULL, the others decay N times.
- Out of range, pos >= NUM_LEDS with step_tick=1: no channel is set to FULL, all channels decay, pos_err <= 1. pos_err stays 1 until reset; it is not cleared by later valid positions.
- Same pos on consecutive steps: that LED stays FULL, the others keep decaying.
- PWM compare, registered:
  - LEDR[i] <= (brightness[i] == FULL) | (pwm_cnt < brightness[i]).
  - FULL is therefore 100% duty with no one-cycle gap; 0 is 0% duty; value b gives b/256 duty.
- Latency:
  - step_tick at cycle T updates brightness at edge T+1.
  - LEDR reflects the new brightness from edge T+2 onward. The new FULL LED is high from T+2.
- Arithmetic: all brightness values are unsigned PWM_BITS. pos is compared zero-extended against channel index constants.
- No handshake back-pressure: the block accepts every step_tick.

Decomposition:
- Shared package (knight_rider_pkg):
  - localparams PWM_BITS_DEF=8 and LED_COUNT=10.
  - FULL_BRIGHTNESS = {PWM_BITS{1'b1}}.
  - POS_W=4. The scanner uses the same LED_COUNT/POS_W.
- Sub-module fader_channel, instantiated NUM_LEDS times via generate. Each instance:
  - Inputs: CLOCK_50, reset, step_tick, is_current, pwm_cnt.
  - Holds its brightness register and its LEDR flop.
- Top level holds pwm_cnt, pos decode / range check, and pos_err.

Test Plan:
- Reset release, no step_tick for 1000 cycles -> LEDR=0 throughout, pos_err=0, pwm_cnt observed wrapping 255->0.
- Single step_tick with pos=3 -> brightness[3]=255; LEDR=10'b0000001000 continuously from T+2; all others stay 0.
- Step pos=3 then steps pos=4,5,...,11 (pos 10/11 out of range) -> brightness[3] sequence 255,127,63,31,15,7,3,1,0. Over one 256-cycle window after brightness[3]=127, LEDR[3] is high exactly 127 cycles (pwm_cnt 0..126). pos_err=1 after the pos=10 step.
- step_tick held high 3 cycles with pos=0, after brightness[1]=255 -> brightness[1]=31, brightness[0]=255.
- pos=12 on a step with brightness[5]=64 -> no LED set FULL, brightness[5]=32, pos_err rises and stays 1 through subsequent valid steps until reset.
- Assert reset mid-sequence, with several LEDs at intermediate brightness and mid PWM period -> LEDR and pos_err go 0 asynchronously (same cycle, before the clock edge). After release, one step pos=9 gives only LEDR[9] lit.
